morse_encoder: RTL and testbench
================================

# morse_encoder

Serial Morse transmitter: accepts one ASCII character per valid/ready handshake and drives the keyed on/off signal with standard unit timing (dot 1 unit, dash 3, element gap 1, letter gap 3, word gap 7). It also emits a per-element symbol stream that uses the same bit convention as the team's Morse decoder (1 = dot, 0 = dash), so the two blocks can be looped back in test. It sits between a character source (UART/keypad front end) and the key/buzzer pin.

## Interface
- UNIT_CYCLES, default 4: clk cycles per Morse time unit; must be ≥1.
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- char_valid  in  1  char_in holds a character to send.
- char_in  in  8  ASCII code; must be stable while char_valid=1 and char_ready=0.
- char_ready  out  1  block can accept; equals (state==IDLE).
- key_out  out  1  Morse key, 1 = tone/mark.
- sym_valid  out  1  one-cycle pulse at the start of each mark.
- sym_bit  out  1  element type qualified by sym_valid: 1 = dot, 0 = dash.
- busy  out  1  state != IDLE.
- err  out  1  one-cycle pulse: unsupported character dropped.

## Operation
- Accept on a cycle with char_valid & char_ready & !reset.
- Supported inputs: 0x41–0x5A (A–Z), 0x61–0x7A (a–z, mapped to uppercase), 0x20 (space). Anything else: character dropped, err=1 next cycle, state stays IDLE.
- Letter lookup returns len (1–4) and pattern[3:0], MSB-first, 1 = dot. Examples: E = len 1, 1; A = len 2, 10; Q = len 4, 0010.
- FSM states: IDLE, MARK, EGAP, LGAP, WGAP.
  - IDLE → MARK on an accepted letter. Load pattern/len and start the first element.
  - MARK: key_out=1 for UNIT_CYCLES (dot) or 3·UNIT_CYCLES (dash). Then go to EGAP if elements remain, else to LGAP.
  - EGAP: key_out=0 for UNIT_CYCLES, then MARK with the next element.
  - LGAP: key_out=0 for 3·UNIT_CYCLES, then IDLE.
  - IDLE → WGAP on space. WGAP: key_out=0 for 4·UNIT_CYCLES, then IDLE. Combined with the preceding LGAP this gives 7 units.
- The last element is followed by LGAP only; no EGAP is inserted before it.
- sym_valid/sym_bit pulse in the first cycle of every MARK.
- Single down-counter, width $clog2(4·UNIT_CYCLES+1), reloaded on every state entry. An element index counts 0..len-1.
- Reset value of every output: key_out=0, sym_valid=0, sym_bit=0, busy=0, err=0. char_ready=1, but char_valid is ignored while reset=1.
- Reset mid-character: the character is abandoned. key_out=0 and IDLE at the next edge; nothing is resumed.

## Timing
- Accept in cycle N. First mark (key_out=1, sym_valid=1) in cycle N+1. No bubble.
- Letter duration in cycles: UNIT_CYCLES·(Σ element units + (len−1) + 3). char_ready returns the cycle after LGAP ends.
- Invalid char: err in N+1, char_ready=1 in N+1, so back-to-back offers are possible.
- No internal queue. A new character is accepted only in IDLE, and IDLE lasts at least one cycle between characters.

## Structure
- morse_pkg: state enum; the ASCII letter constants; the 26-entry code table (len, pattern); the element-unit constants (DOT=1, DASH=3, EGAP=1, LGAP=3, WGAP_EXTRA=4).
- Sub-module morse_code_rom: combinational, char_in[7:0] → {supported, is_space, len[2:0], pattern[3:0]}. The top holds the FSM, counter and shift register.

## Test plan
- UNIT_CYCLES=2, send 'E' (0x45) at N: key_out=1 in N+1..N+2 and 0 in N+3..N+8. One sym pulse with bit=1 at N+1. char_ready=1 at N+9.
- 'A' (0x41): key_out=1 in N+1..N+2, 0 in N+3..N+4, 1 in N+5..N+10, 0 in N+11..N+16. sym pulses at N+1 (bit 1) and N+5 (bit 0). Ready at N+17.
- 'q' (0x71): sym_bit sequence 0,0,1,0; total busy = 2·(3+3+1+3+3+3) = 32 cycles.
- 0x20 then 'T': after the space, key_out=0 for 8 cycles with no sym pulses. Then 'T' produces a 6-cycle mark.
- 0x31: err=1 for exactly one cycle at N+1; key_out stays 0; char_ready=1 at N+1.
- 'O' (0x4F), with reset asserted in the 3rd cycle of the first dash: key_out=0 at the next edge. After reset releases, char_ready=1, busy=0 and no further sym pulses.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse transmitter: FSM states, ASCII
// bounds, element timing in units and the A-Z code table.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    EGAP,
    LGAP,
    WGAP
  } state_t;

  localparam logic [7:0] ASCII_UPPER_A = 8'h41;
  localparam logic [7:0] ASCII_UPPER_Z = 8'h5A;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
  localparam logic [7:0] ASCII_SPACE   = 8'h20;
  localparam logic [7:0] CASE_OFFSET   = 8'h20;

  localparam int DOT_UNITS        = 1;
  localparam int DASH_UNITS       = 3;
  localparam int EGAP_UNITS       = 1;
  localparam int LGAP_UNITS       = 3;
  localparam int WGAP_EXTRA_UNITS = 4;

  typedef struct packed {
    logic [2:0] len;
    logic [3:0] pattern;
  } code_t;

  typedef struct packed {
    logic       supported;
    logic       is_space;
    logic [2:0] len;
    logic [3:0] pattern;
  } rom_out_t;

  // Patterns are left-justified: pattern[3] is the first element, 1 = dot.
  localparam code_t CODE_TABLE [26] = '{
    '{3'd2, 4'b1000},  // A .-
    '{3'd4, 4'b0111},  // B -...
    '{3'd4, 4'b0101},  // C -.-.
    '{3'd3, 4'b0110},  // D -..
    '{3'd1, 4'b1000},  // E .
    '{3'd4, 4'b1101},  // F ..-.
    '{3'd3, 4'b0010},  // G --.
    '{3'd4, 4'b1111},  // H ....
    '{3'd2, 4'b1100},  // I ..
    '{3'd4, 4'b1000},  // J .---
    '{3'd3, 4'b0100},  // K -.-
    '{3'd4, 4'b1011},  // L .-..
    '{3'd2, 4'b0000},  // M --
    '{3'd2, 4'b0100},  // N -.
    '{3'd3, 4'b0000},  // O ---
    '{3'd4, 4'b1001},  // P .--.
    '{3'd4, 4'b0010},  // Q --.-
    '{3'd3, 4'b1010},  // R .-.
    '{3'd3, 4'b1110},  // S ...
    '{3'd1, 4'b0000},  // T -
    '{3'd3, 4'b1100},  // U ..-
    '{3'd4, 4'b1110},  // V ...-
    '{3'd3, 4'b1000},  // W .--
    '{3'd4, 4'b0110},  // X -..-
    '{3'd4, 4'b0100},  // Y -.--
    '{3'd4, 4'b0011}   // Z --..
  };

endpackage

// File: rtl/morse_encoder_if.sv
// Character handshake between a character source and the Morse transmitter.
// A character transfers on a rising edge where char_valid and char_ready are
// both 1; char_in must hold steady while char_valid=1 and char_ready=0.
interface morse_encoder_if;
  logic       char_valid;
  logic [7:0] char_in;
  logic       char_ready;

  modport master (output char_valid, output char_in, input char_ready);
  modport slave  (input char_valid, input char_in, output char_ready);
endinterface

// File: rtl/morse_code_rom.sv
// Combinational ASCII to Morse lookup; lowercase folds onto uppercase and
// space is reported separately so the FSM can emit a word gap.
import morse_pkg::*;

module morse_code_rom (
  input  logic [7:0] char_in,
  output rom_out_t   code
);

  logic [7:0] upper;
  logic [4:0] idx;

  always_comb begin
    upper = char_in;
    idx   = '0;
    code  = '0;
    if (char_in >= ASCII_LOWER_A && char_in <= ASCII_LOWER_Z) begin
      upper = char_in - CASE_OFFSET;
    end
    if (upper >= ASCII_UPPER_A && upper <= ASCII_UPPER_Z) begin
      idx            = 5'(upper - ASCII_UPPER_A);
      code.supported = 1'b1;
      code.len       = CODE_TABLE[idx].len;
      code.pattern   = CODE_TABLE[idx].pattern;
    end else if (char_in == ASCII_SPACE) begin
      code.supported = 1'b1;
      code.is_space  = 1'b1;
    end
  end

endmodule

// File: rtl/morse_encoder.sv
// Serial Morse transmitter: one character per handshake, keyed output with
// standard unit timing plus a dot/dash symbol stream for loopback.
import morse_pkg::*;

module morse_encoder #(
  parameter int UNIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  morse_encoder_if.slave    chan,
  output logic              key_out,
  output logic              sym_valid,
  output logic              sym_bit,
  output logic              busy,
  output logic              err,
  output state_t            state_dbg
);

  localparam int CW = $clog2(4 * UNIT_CYCLES + 1);

  // Counter loads are duration-1 so the state exits on the cycle cnt hits 0.
  localparam logic [CW-1:0] DOT_LOAD  = CW'(DOT_UNITS * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] DASH_LOAD = CW'(DASH_UNITS * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] EGAP_LOAD = CW'(EGAP_UNITS * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] LGAP_LOAD = CW'(LGAP_UNITS * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] WGAP_LOAD = CW'(WGAP_EXTRA_UNITS * UNIT_CYCLES - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    pat, pat_n;
  logic [1:0]    idx, idx_n;
  logic [2:0]    len, len_n;
  logic          sym_valid_n, sym_bit_n, err_n;
  logic          accept;
  logic          last_elem;
  rom_out_t      code;

  morse_code_rom u_rom (
    .char_in (chan.char_in),
    .code    (code)
  );

  assign chan.char_ready = (state == IDLE);
  assign accept          = chan.char_valid && chan.char_ready;
  assign last_elem       = ((3'(idx) + 3'd1) == len);

  assign key_out   = (state == MARK);
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      pat       <= '0;
      idx       <= '0;
      len       <= '0;
      sym_valid <= 1'b0;
      sym_bit   <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pat       <= pat_n;
      idx       <= idx_n;
      len       <= len_n;
      sym_valid <= sym_valid_n;
      sym_bit   <= sym_bit_n;
      err       <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = (cnt != '0) ? cnt - CW'(1) : cnt;
    pat_n       = pat;
    idx_n       = idx;
    len_n       = len;
    sym_valid_n = 1'b0;
    sym_bit_n   = 1'b0;
    err_n       = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (!code.supported) begin
            err_n = 1'b1;
          end else if (code.is_space) begin
            state_n = WGAP;
            cnt_n   = WGAP_LOAD;
          end else begin
            state_n     = MARK;
            pat_n       = code.pattern;
            len_n       = code.len;
            idx_n       = '0;
            cnt_n       = code.pattern[3] ? DOT_LOAD : DASH_LOAD;
            sym_valid_n = 1'b1;
            sym_bit_n   = code.pattern[3];
          end
        end
      end
      MARK: begin
        if (cnt == '0) begin
          if (last_elem) begin
            state_n = LGAP;
            cnt_n   = LGAP_LOAD;
          end else begin
            state_n = EGAP;
            cnt_n   = EGAP_LOAD;
            pat_n   = {pat[2:0], 1'b0};
            idx_n   = idx + 2'd1;
          end
        end
      end
      EGAP: begin
        if (cnt == '0) begin
          state_n     = MARK;
          cnt_n       = pat[3] ? DOT_LOAD : DASH_LOAD;
          sym_valid_n = 1'b1;
          sym_bit_n   = pat[3];
        end
      end
      LGAP, WGAP: begin
        if (cnt == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder at UNIT_CYCLES=2: letters, space, an
// unsupported character and a reset in the middle of a dash.
module tb_morse_encoder;
  import morse_pkg::*;

  localparam int U = 2;

  logic   clk = 1'b0;
  logic   reset;
  logic   key_out, sym_valid, sym_bit, busy, err;
  state_t state_dbg;

  int n_total = 0;
  int n_bad   = 0;

  logic [3:0] exp_q[$];

  morse_encoder_if chan ();

  morse_encoder #(.UNIT_CYCLES(U)) dut (
    .clk       (clk),
    .reset     (reset),
    .chan      (chan),
    .key_out   (key_out),
    .sym_valid (sym_valid),
    .sym_bit   (sym_bit),
    .busy      (busy),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver: returns #1 after the accepting edge, i.e. at the start of cycle N+1
  task automatic offer(input logic [7:0] c);
    int waited;
    waited = 0;
    @(negedge clk);
    chan.char_valid = 1'b1;
    chan.char_in    = c;
    while (!chan.char_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("offer_ready", 32'(chan.char_ready), 32'd1);
    @(posedge clk);
    #1;
    chan.char_valid = 1'b0;
    chan.char_in    = 8'h00;
  endtask

  // expected per cycle: {key_out, sym_valid, sym_valid&sym_bit, busy}
  task automatic check_letter(input string name, input logic [7:0] c,
                              input string els, input int busy_exp);
    int nb;
    int k;
    int mark;
    int gap;
    logic dot;
    logic [3:0] e;
    nb = 0;
    k  = 1;
    exp_q.delete();
    for (int i = 0; i < els.len(); i++) begin
      dot  = (els.getc(i) == 8'h2E);
      mark = (dot ? 1 : 3) * U;
      for (int j = 0; j < mark; j++) exp_q.push_back({1'b1, j == 0, (j == 0) && dot, 1'b1});
      gap = (i == els.len() - 1) ? 3 * U : U;
      for (int j = 0; j < gap; j++) exp_q.push_back(4'b0001);
    end
    exp_q.push_back(4'b0000);
    offer(c);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      if (busy) nb++;
      check($sformatf("%s_cyc%0d", name, k),
            32'({key_out, sym_valid, sym_valid & sym_bit, busy}), 32'(e));
      k++;
    end
    check({name, "_ready_after"}, 32'(chan.char_ready), 32'd1);
    check({name, "_busy_cycles"}, 32'(nb), 32'(busy_exp));
  endtask

  initial begin
    int syms;
    int keys;
    reset           = 1'b1;
    chan.char_valid = 1'b1;
    chan.char_in    = 8'h45;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", 32'({key_out, sym_valid, sym_bit, busy, err}), 32'd0);
    check("rst_ready", 32'(chan.char_ready), 32'd1);
    chan.char_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("rst_idle_busy", 32'(busy), 32'd0);

    check_letter("E", 8'h45, ".", 8);
    check_letter("A", 8'h41, ".-", 16);
    check_letter("q", 8'h71, "--.-", 32);

    // space: 8 silent busy cycles, then idle
    offer(8'h20);
    for (int i = 0; i < 4 * U; i++) begin
      @(negedge clk);
      check($sformatf("space_cyc%0d", i + 1), 32'({key_out, sym_valid, busy}), 32'b001);
    end
    @(negedge clk);
    check("space_ready", 32'({chan.char_ready, busy}), 32'b10);
    check_letter("T", 8'h54, "-", 12);

    // unsupported character
    offer(8'h31);
    @(negedge clk);
    check("err_pulse", 32'(err), 32'd1);
    check("err_key", 32'(key_out), 32'd0);
    check("err_ready", 32'(chan.char_ready), 32'd1);
    @(negedge clk);
    check("err_clear", 32'(err), 32'd0);
    check("err_busy", 32'(busy), 32'd0);

    // lowercase z right after an error: --..
    check_letter("z", 8'h7A, "--..", 2 * (3 + 1 + 3 + 1 + 1 + 1 + 1 + 3));

    // reset in the third cycle of the first dash of 'O'
    offer(8'h4F);
    @(negedge clk);
    check("O_first_sym", 32'({key_out, sym_valid, sym_bit}), 32'b110);
    @(negedge clk);
    @(negedge clk);
    check("O_dash_cyc3", 32'(key_out), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("O_rst_key", 32'(key_out), 32'd0);
    check("O_rst_busy", 32'(busy), 32'd0);
    check("O_rst_ready", 32'(chan.char_ready), 32'd1);
    reset = 1'b0;
    syms = 0;
    keys = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (sym_valid) syms++;
      if (key_out || busy) keys++;
    end
    check("O_no_resume_sym", 32'(syms), 32'd0);
    check("O_no_resume_key", 32'(keys), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
